frame_scanout: RTL and testbench

FRAME_SCANOUT -- requirements
Module: frame_scanout

---
 rtl/frame_scanout.sv | 145 ++++++++++++++
 tb/tb_frame_scanout.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_scanout.sv
`timescale 1ns/1ps
// 640x480@60 VGA scan-out from a 1-bit double-buffered frame buffer.
// Runs at 2x the pixel clock; the odd phase advances the raster and loads the output registers.
module frame_scanout #(
  parameter logic [23:0] FG_COLOR  = 24'hFFFFFF,
  parameter logic [23:0] BG_COLOR  = 24'h000000,
  parameter int          H_VISIBLE = 640,
  parameter int          H_FRONT   = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BACK    = 48,
  parameter int          V_VISIBLE = 480,
  parameter int          V_FRONT   = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BACK    = 33
) (
  input  logic       Clk,
  input  logic       Reset_n,
  output logic [9:0] ReadX,
  output logic [9:0] ReadY,
  input  logic       read_data,
  input  logic       swap_req,
  output logic       swap_ack,
  output logic       buf_sel,
  output logic       frame_start,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N
);

  localparam logic [9:0] H_VIS        = 10'(H_VISIBLE);
  localparam logic [9:0] H_SWAP       = 10'(H_VISIBLE - 1);
  localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] H_LAST       = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
  localparam logic [9:0] V_SWAP       = 10'(V_VISIBLE - 1);
  localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] V_LAST       = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

  logic        ph_q, ph_d;
  logic [9:0]  hc_q, hc_d;
  logic [9:0]  vc_q, vc_d;
  logic        pending_q, pending_d;
  logic        buf_sel_q, buf_sel_d;
  logic        swap_ack_q, swap_ack_d;
  logic        frame_start_q, frame_start_d;
  logic [23:0] rgb_q, rgb_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        blank_n_q, blank_n_d;

  logic        adv;
  logic        h_wrap;
  logic        v_wrap;
  logic        visible;
  logic        swap_point;
  logic        do_swap;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ph_q          <= 1'b0;
      hc_q          <= '0;
      vc_q          <= '0;
      pending_q     <= 1'b0;
      buf_sel_q     <= 1'b0;
      swap_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
      rgb_q         <= '0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b0;
    end else begin
      ph_q          <= ph_d;
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      pending_q     <= pending_d;
      buf_sel_q     <= buf_sel_d;
      swap_ack_q    <= swap_ack_d;
      frame_start_q <= frame_start_d;
      rgb_q         <= rgb_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_n_q     <= blank_n_d;
    end
  end

  always_comb begin
    ph_d    = ~ph_q;
    adv     = ph_q;
    h_wrap  = (hc_q == H_LAST);
    v_wrap  = (vc_q == V_LAST);
    visible = (hc_q < H_VIS) && (vc_q < V_VIS);

    hc_d = hc_q;
    vc_d = vc_q;
    if (adv) begin
      hc_d = h_wrap ? 10'd0 : hc_q + 10'd1;
      if (h_wrap) begin
        vc_d = v_wrap ? 10'd0 : vc_q + 10'd1;
      end
    end

    // The address holds for both phases, so read_data at the odd edge belongs to hc_q.
    ReadX = visible ? hc_q : 10'd0;
    ReadY = visible ? vc_q : 10'd0;

    rgb_d     = rgb_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    blank_n_d = blank_n_q;
    if (adv) begin
      rgb_d     = visible ? (read_data ? FG_COLOR : BG_COLOR) : 24'h000000;
      blank_n_d = visible;
      hs_d      = ~((hc_q >= H_SYNC_START) && (hc_q <= H_SYNC_END));
      vs_d      = ~((vc_q >= V_SYNC_START) && (vc_q <= V_SYNC_END));
    end

    // Swap only on the last visible pixel, so the displayed buffer never changes mid-picture.
    swap_point    = adv && (hc_q == H_SWAP) && (vc_q == V_SWAP);
    do_swap       = swap_point && (pending_q || swap_req);
    pending_d     = do_swap ? 1'b0 : (pending_q | swap_req);
    buf_sel_d     = buf_sel_q ^ do_swap;
    swap_ack_d    = do_swap;
    frame_start_d = adv && h_wrap && v_wrap;
  end

  assign swap_ack    = swap_ack_q;
  assign buf_sel     = buf_sel_q;
  assign frame_start = frame_start_q;
  assign VGA_R       = rgb_q[23:16];
  assign VGA_G       = rgb_q[15:8];
  assign VGA_B       = rgb_q[7:0];
  assign VGA_CLK     = ph_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_frame_scanout.sv
`timescale 1ns/1ps
// Bench for frame_scanout: a shrunken raster (16x12, 8x6 visible) for frame-level behaviour,
// plus a default-timing instance for the real 640x480 horizontal timing.
module tb_frame_scanout;

  localparam logic [23:0] FG = 24'hA5C30F;
  localparam logic [23:0] BG = 24'h1E2D3C;

  logic Clk = 1'b0;
  always #10 Clk = ~Clk;

  logic       Reset_n;
  logic       swap_req;
  logic       s_rd = 1'b0;
  logic       d_rd = 1'b0;

  logic [9:0] s_rx, s_ry, d_rx, d_ry;
  logic       s_ack, s_buf, s_fs, s_vclk, s_hs, s_vs, s_blank, s_syncn;
  logic [7:0] s_r, s_g, s_b;
  logic       d_ack, d_buf, d_fs, d_vclk, d_hs, d_vs, d_blank, d_syncn;
  logic [7:0] d_r, d_g, d_b;

  frame_scanout #(
    .FG_COLOR(FG), .BG_COLOR(BG),
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .ReadX(s_rx), .ReadY(s_ry), .read_data(s_rd),
    .swap_req(swap_req), .swap_ack(s_ack), .buf_sel(s_buf), .frame_start(s_fs),
    .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b), .VGA_CLK(s_vclk), .VGA_HS(s_hs),
    .VGA_VS(s_vs), .VGA_BLANK_N(s_blank), .VGA_SYNC_N(s_syncn)
  );

  frame_scanout dut_def (
    .Clk(Clk), .Reset_n(Reset_n), .ReadX(d_rx), .ReadY(d_ry), .read_data(d_rd),
    .swap_req(1'b0), .swap_ack(d_ack), .buf_sel(d_buf), .frame_start(d_fs),
    .VGA_R(d_r), .VGA_G(d_g), .VGA_B(d_b), .VGA_CLK(d_vclk), .VGA_HS(d_hs),
    .VGA_VS(d_vs), .VGA_BLANK_N(d_blank), .VGA_SYNC_N(d_syncn)
  );

  // Frame-buffer model: registered read returning the column LSB.
  always @(posedge Clk) begin
    s_rd <= s_rx[0];
    d_rd <= d_rx[0];
  end

  int edge_cnt;
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) edge_cnt <= 0;
    else          edge_cnt <= edge_cnt + 1;
  end

  int ack_cnt = 0;
  always @(negedge Clk) if (s_ack === 1'b1) ack_cnt <= ack_cnt + 1;

  int checks = 0;
  int errors = 0;
  logic rel_done = 1'b0;
  logic def_done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", nm, edge_cnt, act, exp_v);
    end
  endtask

  task automatic wait_edge(input int e);
    int guard;
    guard = 0;
    while (edge_cnt < e && guard < 200000) begin
      @(negedge Clk);
      guard++;
    end
    if (edge_cnt != e) begin
      checks++;
      errors++;
      $display("FAIL wait_edge target %0d reached %0d", e, edge_cnt);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " rgb"},   {8'h0, s_r, s_g, s_b}, 32'h0);
    chk({tag, " hs"},    {31'h0, s_hs}, 32'h1);
    chk({tag, " vs"},    {31'h0, s_vs}, 32'h1);
    chk({tag, " blank"}, {31'h0, s_blank}, 32'h0);
    chk({tag, " ack"},   {31'h0, s_ack}, 32'h0);
    chk({tag, " fs"},    {31'h0, s_fs}, 32'h0);
    chk({tag, " buf"},   {31'h0, s_buf}, 32'h0);
    chk({tag, " vclk"},  {31'h0, s_vclk}, 32'h0);
    chk({tag, " rx"},    {22'h0, s_rx}, 32'h0);
    chk({tag, " ry"},    {22'h0, s_ry}, 32'h0);
    chk({tag, " syncn"}, {31'h0, s_syncn}, 32'h0);
    chk({tag, " def rgb"}, {8'h0, d_r, d_g, d_b}, 32'h0);
    chk({tag, " def hs"},  {31'h0, d_hs}, 32'h1);
  endtask

  typedef struct {
    int          edge_n;
    logic [9:0]  rx;
    logic [9:0]  ry;
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        blank;
    logic        fs;
  } vec_t;

  vec_t vecs[24];

  initial begin
    #(20 * 20000);
    $display("FAIL watchdog expired at edge %0d", edge_cnt);
    $fatal(1, "watchdog");
  end

  // Default-timing instance: colours, visible edge and the 192-Clk / 1600-Clk HS timing.
  initial begin
    wait (rel_done);
    wait_edge(2);    chk("def rgb hc0", {8'h0, d_r, d_g, d_b}, 32'h000000);
                     chk("def blank hc0", {31'h0, d_blank}, 32'h1);
    wait_edge(4);    chk("def rgb hc1", {8'h0, d_r, d_g, d_b}, 32'hFFFFFF);
    wait_edge(1278); chk("def rx 639", {22'h0, d_rx}, 32'd639);
    wait_edge(1280); chk("def rgb hc639", {8'h0, d_r, d_g, d_b}, 32'hFFFFFF);
                     chk("def blank hc639", {31'h0, d_blank}, 32'h1);
                     chk("def rx 640", {22'h0, d_rx}, 32'd0);
    wait_edge(1282); chk("def rgb hc640", {8'h0, d_r, d_g, d_b}, 32'h0);
                     chk("def blank hc640", {31'h0, d_blank}, 32'h0);
    wait_edge(1313); chk("def hs hc655", {31'h0, d_hs}, 32'h1);
    wait_edge(1314); chk("def hs hc656", {31'h0, d_hs}, 32'h0);
    wait_edge(1505); chk("def hs hc751", {31'h0, d_hs}, 32'h0);
    wait_edge(1506); chk("def hs hc752", {31'h0, d_hs}, 32'h1);
    wait_edge(2913); chk("def hs line1 hc655", {31'h0, d_hs}, 32'h1);
    wait_edge(2914); chk("def hs line1 hc656", {31'h0, d_hs}, 32'h0);
                     chk("def vs line1", {31'h0, d_vs}, 32'h1);
    def_done = 1'b1;
  end

  initial begin
    int sp;
    logic exp_buf;

    //             edge  rx     ry     rgb     hs    vs    blank fs
    vecs[0]  = '{0,   10'd0, 10'd0, 24'h0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1,   10'd0, 10'd0, 24'h0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{2,   10'd1, 10'd0, BG,    1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{4,   10'd2, 10'd0, FG,    1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{5,   10'd2, 10'd0, FG,    1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{6,   10'd3, 10'd0, BG,    1'b1, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{16,  10'd0, 10'd0, FG,    1'b1, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{18,  10'd0, 10'd0, 24'h0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{22,  10'd0, 10'd0, 24'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{26,  10'd0, 10'd0, 24'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{28,  10'd0, 10'd0, 24'h0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{34,  10'd1, 10'd1, BG,    1'b1, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{36,  10'd2, 10'd1, FG,    1'b1, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{174, 10'd7, 10'd5, BG,    1'b1, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{176, 10'd0, 10'd0, FG,    1'b1, 1'b1, 1'b1, 1'b0};
    vecs[15] = '{194, 10'd0, 10'd0, 24'h0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{256, 10'd0, 10'd0, 24'h0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[17] = '{258, 10'd0, 10'd0, 24'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{290, 10'd0, 10'd0, 24'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{322, 10'd0, 10'd0, 24'h0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[20] = '{383, 10'd0, 10'd0, 24'h0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[21] = '{384, 10'd0, 10'd0, 24'h0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[22] = '{385, 10'd0, 10'd0, 24'h0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[23] = '{386, 10'd1, 10'd0, BG,    1'b1, 1'b1, 1'b1, 1'b0};

    swap_req = 1'b0;
    Reset_n  = 1'b1;
    #2 Reset_n = 1'b0;
    #13 check_reset_vals("por");
    @(negedge Clk);
    Reset_n  = 1'b1;
    rel_done = 1'b1;

    for (int i = 0; i < 24; i++) begin
      wait_edge(vecs[i].edge_n);
      chk("rx",    {22'h0, s_rx}, {22'h0, vecs[i].rx});
      chk("ry",    {22'h0, s_ry}, {22'h0, vecs[i].ry});
      chk("rgb",   {8'h0, s_r, s_g, s_b}, {8'h0, vecs[i].rgb});
      chk("hs",    {31'h0, s_hs}, {31'h0, vecs[i].hs});
      chk("vs",    {31'h0, s_vs}, {31'h0, vecs[i].vs});
      chk("blank", {31'h0, s_blank}, {31'h0, vecs[i].blank});
      chk("fs",    {31'h0, s_fs}, {31'h0, vecs[i].fs});
      chk("vclk",  {31'h0, s_vclk}, {31'h0, vecs[i].edge_n[0]});
      $display("vec %0d edge %0d rx=%0d ry=%0d rgb=%06h hs=%b vs=%b blank=%b fs=%b",
               i, edge_cnt, s_rx, s_ry, {s_r, s_g, s_b}, s_hs, s_vs, s_blank, s_fs);
    end

    // One-Clk request mid-frame: one ack at the swap point, none in the following frame.
    wait_edge(448); swap_req = 1'b1;
    wait_edge(449); swap_req = 1'b0;
    wait_edge(559); chk("pulse ack pre", {31'h0, s_ack}, 32'h0); chk("pulse buf pre", {31'h0, s_buf}, 32'h0);
    wait_edge(560); chk("pulse ack", {31'h0, s_ack}, 32'h1);     chk("pulse buf", {31'h0, s_buf}, 32'h1);
    wait_edge(561); chk("pulse ack post", {31'h0, s_ack}, 32'h0);
    wait_edge(944); chk("next frame ack", {31'h0, s_ack}, 32'h0); chk("next frame buf", {31'h0, s_buf}, 32'h1);
    wait_edge(946); chk("ack count a", ack_cnt, 32'd1);
    $display("swap pulse: ack_cnt=%0d buf=%b", ack_cnt, s_buf);

    // Request raised exactly in the swap-point cycle.
    wait_edge(1327); swap_req = 1'b1;
    wait_edge(1328); swap_req = 1'b0;
    chk("late ack", {31'h0, s_ack}, 32'h1); chk("late buf", {31'h0, s_buf}, 32'h0);
    wait_edge(1329); chk("late ack post", {31'h0, s_ack}, 32'h0);
    wait_edge(1712); chk("late next ack", {31'h0, s_ack}, 32'h0); chk("late next buf", {31'h0, s_buf}, 32'h0);
    wait_edge(1800); chk("ack count b", ack_cnt, 32'd2);
    $display("swap late: ack_cnt=%0d buf=%b", ack_cnt, s_buf);

    // Held request for three frames: one swap per frame.
    swap_req = 1'b1;
    exp_buf  = 1'b0;
    for (int k = 5; k <= 7; k++) begin
      sp = 384 * k + 176;
      exp_buf = ~exp_buf;
      wait_edge(sp - 1); chk("held ack pre", {31'h0, s_ack}, 32'h0);
      wait_edge(sp);     chk("held ack", {31'h0, s_ack}, 32'h1);
                         chk("held buf", {31'h0, s_buf}, {31'h0, exp_buf});
      if (k == 7) swap_req = 1'b0;
      wait_edge(sp + 1); chk("held ack post", {31'h0, s_ack}, 32'h0);
      $display("swap held frame %0d: buf=%b", k, s_buf);
    end
    wait_edge(3248); chk("after held ack", {31'h0, s_ack}, 32'h0); chk("after held buf", {31'h0, s_buf}, 32'h1);
    wait_edge(3250); chk("ack count c", ack_cnt, 32'd5);

    // Reset mid-frame with a swap pending.
    wait_edge(3496); swap_req = 1'b1;
    wait_edge(3497); swap_req = 1'b0;
    wait_edge(3528);
    chk("pre-reset rgb", {8'h0, s_r, s_g, s_b}, {8'h0, FG});
    chk("pre-reset blank", {31'h0, s_blank}, 32'h1);
    #3 Reset_n = 1'b0;
    #1 check_reset_vals("mid");
    #30;
    @(negedge Clk);
    Reset_n = 1'b1;
    wait_edge(1);   chk("rst rx e1", {22'h0, s_rx}, 32'd0); chk("rst vclk e1", {31'h0, s_vclk}, 32'h1);
    wait_edge(2);   chk("rst rx e2", {22'h0, s_rx}, 32'd1);
    wait_edge(176); chk("rst swap ack", {31'h0, s_ack}, 32'h0); chk("rst swap buf", {31'h0, s_buf}, 32'h0);
    wait_edge(383); chk("rst fs pre", {31'h0, s_fs}, 32'h0);
    wait_edge(384); chk("rst fs", {31'h0, s_fs}, 32'h1);
    wait_edge(385); chk("rst fs post", {31'h0, s_fs}, 32'h0);
    wait_edge(400); chk("ack count d", ack_cnt, 32'd5);
    $display("reset mid-frame: ack_cnt=%0d buf=%b", ack_cnt, s_buf);

    if (!def_done) begin
      checks++;
      errors++;
      $display("FAIL def_done not reached");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
